// File: rtl/dice_roll_controller.sv
// Turn sequencer for the four-die generator: button edge -> timed tumble burst,
// then capture with hold mask, roll accounting and dice total.
module dice_roll_controller #(
    parameter int TUMBLE_CYCLES = 16,
    parameter int MAX_ROLLS     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_btn,
    input  logic       new_turn,
    input  logic [3:0] hold,
    input  logic [3:0] rand_in1,
    input  logic [3:0] rand_in2,
    input  logic [3:0] rand_in3,
    input  logic [3:0] rand_in4,
    output logic       roll_trigger,
    output logic [3:0] die1,
    output logic [3:0] die2,
    output logic [3:0] die3,
    output logic [3:0] die4,
    output logic [4:0] sum,
    output logic [1:0] rolls_left,
    output logic       busy,
    output logic       roll_done,
    output logic       turn_over
);

    // state     | meaning
    // S_IDLE    | waiting for a roll edge or new_turn
    // S_TUMBLE  | roll_trigger high, counting TUMBLE_CYCLES
    // S_CAPTURE | sample generator outputs under hold mask
    // S_REPORT  | total the dice
    // S_DONE    | no rolls left, waiting for new_turn
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TUMBLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [7:0] TC_LAST    = 8'(TUMBLE_CYCLES - 1);
    localparam logic [1:0] ROLLS_INIT = 2'(MAX_ROLLS);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       btn_q;
    logic [3:0] die_q [4];
    logic [3:0] die_d [4];
    logic [4:0] sum_q, sum_d;
    logic [1:0] left_q, left_d;
    logic       trig_q, busy_q, done_q, over_q;
    logic [3:0] rand_v [4];
    logic       start;
    logic       first_roll;

    // Generator values outside 1..6 are forced to 1 so a die is never blank after a roll.
    function automatic logic [3:0] clamp_die(input logic [3:0] v);
        return ((v == 4'd0) || (v > 4'd6)) ? 4'd1 : v;
    endfunction

    assign rand_v[0]  = rand_in1;
    assign rand_v[1]  = rand_in2;
    assign rand_v[2]  = rand_in3;
    assign rand_v[3]  = rand_in4;
    assign start      = roll_btn & ~btn_q;
    assign first_roll = (left_q == ROLLS_INIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        die_d   = die_q;
        sum_d   = sum_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE: begin
                if (new_turn) begin
                    die_d  = '{default: '0};
                    sum_d  = '0;
                    left_d = ROLLS_INIT;
                end else if (start && (left_q != 2'd0)) begin
                    state_d = S_TUMBLE;
                    cnt_d   = '0;
                end
            end
            S_TUMBLE: begin
                if (cnt_q == TC_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < 4; i++) begin
                    if (first_roll || !hold[i]) begin
                        die_d[i] = clamp_die(rand_v[i]);
                    end
                end
                left_d  = left_q - 2'd1;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                sum_d   = 5'(die_q[0]) + 5'(die_q[1]) + 5'(die_q[2]) + 5'(die_q[3]);
                state_d = (left_q == 2'd0) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (new_turn) begin
                    die_d   = '{default: '0};
                    sum_d   = '0;
                    left_d  = ROLLS_INIT;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b1;
            die_q   <= '{default: '0};
            sum_q   <= '0;
            left_q  <= ROLLS_INIT;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= roll_btn;
            die_q   <= die_d;
            sum_q   <= sum_d;
            left_q  <= left_d;
            trig_q  <= (state_d == S_TUMBLE);
            busy_q  <= (state_d == S_TUMBLE) || (state_d == S_CAPTURE) || (state_d == S_REPORT);
            done_q  <= (state_q == S_REPORT);
            over_q  <= (state_d == S_DONE);
        end
    end

    assign roll_trigger = trig_q;
    assign die1         = die_q[0];
    assign die2         = die_q[1];
    assign die3         = die_q[2];
    assign die4         = die_q[3];
    assign sum          = sum_q;
    assign rolls_left   = left_q;
    assign busy         = busy_q;
    assign roll_done    = done_q;
    assign turn_over    = over_q;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Randomized self-checking bench for dice_roll_controller against a turn-level model.
module tb_dice_roll_controller;

    localparam int T   = 4;
    localparam int MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       roll_btn = 1'b1;
    logic       new_turn = 1'b0;
    logic [3:0] hold = 4'd0;
    logic [3:0] rand_in1 = 4'd0, rand_in2 = 4'd0, rand_in3 = 4'd0, rand_in4 = 4'd0;
    logic       roll_trigger, busy, roll_done, turn_over;
    logic [3:0] die1, die2, die3, die4;
    logic [4:0] sum;
    logic [1:0] rolls_left;

    int n_cmp = 0;
    int n_bad = 0;

    int m_dice [4];
    int m_left;

    dice_roll_controller #(.TUMBLE_CYCLES(T), .MAX_ROLLS(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .roll_btn(roll_btn), .new_turn(new_turn), .hold(hold),
        .rand_in1(rand_in1), .rand_in2(rand_in2), .rand_in3(rand_in3), .rand_in4(rand_in4),
        .roll_trigger(roll_trigger), .die1(die1), .die2(die2), .die3(die3), .die4(die4),
        .sum(sum), .rolls_left(rolls_left), .busy(busy), .roll_done(roll_done),
        .turn_over(turn_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int face(input int v);
        return (v >= 1 && v <= 6) ? v : 1;
    endfunction

    task automatic model_new_turn();
        for (int d = 0; d < 4; d++) m_dice[d] = 0;
        m_left = MAX;
    endtask

    task automatic check_turn(input string tag);
        chk({tag, ".die1"}, die1, m_dice[0]);
        chk({tag, ".die2"}, die2, m_dice[1]);
        chk({tag, ".die3"}, die3, m_dice[2]);
        chk({tag, ".die4"}, die4, m_dice[3]);
        chk({tag, ".sum"}, sum, m_dice[0] + m_dice[1] + m_dice[2] + m_dice[3]);
        chk({tag, ".left"}, rolls_left, m_left);
        chk({tag, ".over"}, turn_over, (m_left == 0));
    endtask

    task automatic set_gen(input int a, input int b, input int c, input int d, input int h);
        rand_in1 = 4'(a); rand_in2 = 4'(b); rand_in3 = 4'(c); rand_in4 = 4'(d); hold = 4'(h);
    endtask

    // One button press; the window after the detecting edge is checked cycle by cycle.
    task automatic do_roll(input string tag, input bit extra);
        bit go;
        int rv [4];
        go = (m_left != 0);
        rv[0] = rand_in1; rv[1] = rand_in2; rv[2] = rand_in3; rv[3] = rand_in4;
        @(negedge clk) roll_btn = 1'b0;
        @(negedge clk) roll_btn = 1'b1;
        for (int i = 0; i < T + 5; i++) begin
            @(posedge clk); #1;
            chk({tag, ".trig"}, roll_trigger, go && (i < T));
            chk({tag, ".busy"}, busy, go && (i < T + 2));
            chk({tag, ".rdone"}, roll_done, go && (i == T + 2));
            if (go && i == T + 2) begin
                for (int d = 0; d < 4; d++)
                    if (m_left == MAX || !hold[d]) m_dice[d] = face(rv[d]);
                m_left--;
                check_turn(tag);
            end
            if (i == 0) roll_btn = 1'b0;
            if (i == 1 && extra) roll_btn = 1'b1;
            if (i == 3) roll_btn = 1'b0;
        end
        hold = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        check_turn({tag, ".after"});
    endtask

    task automatic do_new_turn(input string tag, input bit with_btn);
        @(negedge clk) roll_btn = 1'b0;
        @(negedge clk) begin new_turn = 1'b1; roll_btn = with_btn; end
        @(posedge clk); #1;
        new_turn = 1'b0;
        model_new_turn();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk({tag, ".trig"}, roll_trigger, 0);
            chk({tag, ".busy"}, busy, 0);
        end
        roll_btn = 1'b0;
        check_turn(tag);
    endtask

    initial begin
        model_new_turn();
        // reset with button held: no roll until a fresh edge
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check_turn("rst");
        chk("rst.trig", roll_trigger, 0);
        chk("rst.busy", busy, 0);
        chk("rst.rdone", roll_done, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("held.trig", roll_trigger, 0);
        end

        set_gen(3, 5, 2, 6, 4'b1111);
        do_roll("roll1", 1'b0);
        chk("roll1.sum16", sum, 16);
        set_gen(1, 1, 1, 1, 4'b0101);
        do_roll("roll2", 1'b1);
        chk("roll2.sum7", sum, 7);
        set_gen(4, 4, 4, 4, 4'b0000);
        do_roll("roll3", 1'b0);
        do_roll("dead", 1'b0);
        do_new_turn("nt", 1'b0);

        // asynchronous reset in the second tumble cycle
        set_gen(2, 2, 2, 2, 0);
        @(negedge clk) roll_btn = 1'b0;
        @(negedge clk) roll_btn = 1'b1;
        @(posedge clk); #1;
        roll_btn = 1'b0;
        @(posedge clk); #1;
        chk("mid.trig_pre", roll_trigger, 1);
        rst_n = 1'b0;
        #1;
        chk("mid.trig", roll_trigger, 0);
        chk("mid.busy", busy, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_new_turn();
        for (int i = 0; i < T + 4; i++) begin
            @(posedge clk); #1;
            chk("mid.rdone", roll_done, 0);
            chk("mid.trig_after", roll_trigger, 0);
        end
        check_turn("mid");

        set_gen(0, 7, 6, 15, 4'b1010);
        do_roll("clamp", 1'b0);
        chk("clamp.sum9", sum, 9);
        do_new_turn("nt_btn", 1'b1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_new_turn("rnd_nt", 1'($urandom_range(0, 1)));
            end else begin
                set_gen($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15));
                do_roll("rnd", 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dice_roll_controller.md
Name: dice_roll_controller

Overview:
- Turn sequencer for the four-die random value generator, which advances its four 1..6 outputs on every cycle its roll_trigger input is high.
- Converts a roll button edge into a timed tumble burst on roll_trigger, then captures the generator outputs into per-die registers, honouring a hold mask.
- Tracks remaining rolls per turn and reports the dice total.
- Sits between the board switches/buttons and the generator; its dice and sum outputs feed the display logic.

Parameters:
- TUMBLE_CYCLES, 16: number of consecutive cycles roll_trigger is held high per roll. Legal range 1..255; internal counter is 8 bits.
- MAX_ROLLS, 3: rolls allowed per turn. Legal range 1..3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- roll_btn  in  1  roll request, already debounced and synchronised. Only a rising edge acts.
- new_turn  in  1  single-cycle pulse that starts a new turn.
- hold  in  4  per-die hold mask. bit0 = die1 … bit3 = die4.
- rand_in1, rand_in2, rand_in3, rand_in4  in  4 each  generator outputs.
- roll_trigger  out  1  drives the generator's roll_trigger input.
- die1, die2, die3, die4  out  4 each  captured die values. 0 = not yet rolled this turn.
- sum  out  5  die1+die2+die3+die4, range 0..24.
- rolls_left  out  2  rolls remaining in the current turn.
- busy  out  1  high while in TUMBLE, CAPTURE or REPORT.
- roll_done  out  1  one-cycle pulse marking a completed roll.
- turn_over  out  1  high in the DONE state.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-roll):
  - state = IDLE; die1..4 = 0; sum = 0; rolls_left = MAX_ROLLS.
  - roll_trigger, busy, roll_done, turn_over = 0.
  - Tumble counter = 0; roll_btn edge register = 1, so a button held through reset release does not trigger a roll.
- Edge detect: start condition = roll_btn & ~roll_btn_q, sampled every cycle. Edges seen outside IDLE are discarded, not queued.
- All outputs are registered.
- State machine:
  - IDLE:
    - new_turn = 1 → reinitialise the turn: dice = 0, sum = 0, rolls_left = MAX_ROLLS; stay in IDLE.
    - new_turn has priority; a simultaneous roll edge is dropped.
    - Otherwise, an edge with rolls_left != 0 → TUMBLE.
  - TUMBLE:
    - roll_trigger = 1, busy = 1.
    - Counter runs 0..TUMBLE_CYCLES-1; on reaching the terminal count → CAPTURE.
    - If the edge is detected at clock k, roll_trigger is high in cycles k+1..k+TUMBLE_CYCLES exactly.
  - CAPTURE:
    - One cycle; roll_trigger = 0. rand_in1..4 and hold are sampled here.
    - For each die: if this is the first roll of the turn (rolls_left == MAX_ROLLS) or its hold bit = 0, die <= rand_in. Otherwise the die is unchanged.
    - A rand_in value of 0 or greater than 6 is captured as 1.
    - rolls_left decrements by 1.
    - If hold = 4'b1111 on a later roll, the roll is still consumed.
    - → REPORT.
  - REPORT:
    - One cycle; sum <= zero-extended total of the four dice.
    - → DONE if rolls_left == 0, else → IDLE.
  - DONE:
    - turn_over = 1; roll edges are ignored and roll_trigger stays 0.
    - new_turn → reinitialise as in IDLE, turn_over <= 0, → IDLE.
- roll_done is high only in cycle k+TUMBLE_CYCLES+3: the first cycle in which the new dice, sum and rolls_left are all visible.
- busy is high in cycles k+1..k+TUMBLE_CYCLES+2.
- new_turn during TUMBLE, CAPTURE or REPORT is ignored.
- hold changes outside the CAPTURE cycle have no effect.
- sum never overflows: maximum 24 fits in 5 bits.

Test Plan:
1. Reset: assert rst_n = 0 with roll_btn = 1 held, then release → all outputs at reset values, rolls_left = 3, and no roll starts until roll_btn goes 0 then 1.
2. First roll (TUMBLE_CYCLES = 4), generator stub holds 3,5,2,6, hold = 4'b1111 → hold ignored; roll_trigger high exactly 4 cycles; roll_done at k+7; dice = 3,5,2,6; sum = 16; rolls_left = 2.
3. Second roll with hold = 4'b0101, stub 1,1,1,1 → dice = 3,1,2,1; sum = 7; rolls_left = 1. An extra roll_btn edge during TUMBLE does not start another roll.
4. Third roll → rolls_left = 0 and turn_over = 1 at roll_done. A following edge leaves roll_trigger at 0. new_turn → dice = 0, sum = 0, rolls_left = 3, turn_over = 0.
5. rst_n pulsed low in the 2nd TUMBLE cycle → roll_trigger drops immediately, no roll_done, dice = 0, state IDLE.
6. Stub outputs 0,7,6,15 → dice = 1,1,6,1, sum = 9. Then new_turn and a roll edge in the same IDLE cycle → turn reinitialised and no TUMBLE entered.
